jt7759_romarb: RTL and testbench
================================

Name: jt7759_romarb

Overview:
Shares one external sample-ROM port between two jt7759 ADPCM channels (two jt7759_ctrl instances, ch0/ch1). Each channel keeps its native cs/addr/data/ok handshake: hold cs high with a stable address and wait for ok.
The arbiter grants one access at a time, relocates channel 1 into its own ROM region, and returns data through a per-channel one-entry holding register. Sits between the channel controllers and the board SDRAM/BRAM loader.

Parameters:
ROM_AW, 18, width of downstream ROM address
CH1_OFFSET, 18'h20000, base added to ch1 addresses (modulo 2^ROM_AW)
PRIO, 0, 0 = round-robin on contention; 1 = fixed priority to ch0

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
ch0_cs  in  1  ch0 read request (level)
ch0_addr  in  17  ch0 byte address
ch0_data  out  8  ch0 returned byte
ch0_ok  out  1  ch0_data valid for current ch0_addr
ch1_cs  in  1  ch1 read request
ch1_addr  in  17  ch1 byte address
ch1_data  out  8  ch1 returned byte
ch1_ok  out  1  ch1_data valid for current ch1_addr
rom_cs  out  1  downstream request
rom_addr  out  ROM_AW  downstream address
rom_data  in  8  downstream data
rom_ok  in  1  downstream data valid

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous, active-low.
- Per-channel slot registers: tag[16:0], data[7:0], valid.
  - chN_ok = chN_cs & valid & (tag == chN_addr), combinational from registers.
  - chN_data = slot data register at all times.
- valid clears on any cycle with chN_cs=0. A one-cycle cs drop therefore forces a fresh fetch.
- pending_N = chN_cs & ~chN_ok.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE:
    - If either channel is pending: latch lat_addr = chN_addr and gnt = N, then go to ISSUE.
    - Contention, PRIO=0: grant the channel not served last (last_gnt).
    - Contention, PRIO=1: grant ch0.
  - ISSUE (1 cycle):
    - rom_cs=1.
    - rom_addr = zero-extended lat_addr, plus CH1_OFFSET if gnt=1, truncated to ROM_AW bits (wraps).
    - rom_ok is ignored in this cycle (stale-data guard). Go to WAIT.
  - WAIT: rom_cs=1 and rom_addr held. On rom_ok:
    - Write slot[gnt]: tag=lat_addr, data=rom_data, valid=1.
    - Set last_gnt=gnt, drop rom_cs, go to IDLE.
- Minimum latency: cs rises at cycle 0, rom_cs is high in cycles 1–2, rom_ok arrives in cycle 2, chN_ok is high in cycle 3. Waiting in WAIT adds cycles one for one.
- Accesses are never cancelled:
  - If the granted channel drops cs or changes address during ISSUE/WAIT, the access still completes and the slot is written.
  - If cs is still low at write time, valid is not set; clear wins over set.
  - A changed address gives a tag mismatch, so ok stays 0.
- Back-to-back operation:
  - Earliest next grant is the cycle after the return to IDLE.
  - With both channels continuously pending, grants alternate 0,1,0,1 (PRIO=0).
- rom_addr holds its last value while rom_cs=0.
- Reset values: rom_cs=0, rom_addr=0, ch0/ch1_data=0, ch0/ch1_ok=0, all valid=0, tags=0, state=IDLE, last_gnt=1 (ch0 wins the first tie).
- Reset mid-access: all registers take reset values immediately and rom_cs drops asynchronously. The pending access is discarded.

Decomposition:
- Shared package jt7759_pkg:
  - FSM state localparams (one-hot, 3 bits).
  - Channel address width 17.
  - Default ROM_AW.
- Sub-module jt7759_romarb_slot: tag/data/valid registers, hit compare and ok generation. Instantiated twice; the top holds the FSM, grant logic and address offset.

Test Plan:
1. After reset, ch0_cs=1, ch0_addr=17'h00103, model returns rom_ok one cycle after ISSUE with data 8'h5A -> rom_addr=18'h00103 in cycle 1; ch0_ok=1 and ch0_data=8'h5A in cycle 3; rom_cs=0 in cycle 3.
2. ch1_cs=1, ch1_addr=17'h1FFFF, CH1_OFFSET=18'h20000 -> rom_addr=18'h3FFFF. Repeat with CH1_OFFSET=18'h30000 -> rom_addr=18'h0FFFF (wrap).
3. Both channels request in the same cycle, continuous new addresses, PRIO=0 -> grants 0,1,0,1. With PRIO=1 -> grants 0,0,0 while ch0 keeps requesting; ch1 is served only when ch0 is satisfied.
4. ch0 changes address from 17'h00010 to 17'h00011 while in WAIT -> the access to 17'h00010 completes; ch0_ok stays 0; a new access to 17'h00011 is issued next; ch0_ok rises only for 17'h00011.
5. ch0_cs pulses low for one cycle with the same address after ch0_ok=1 -> ch0_ok falls in the low cycle; a fresh downstream read is issued; ch0_ok returns after at least 3 cycles.
6. rst_n asserted while in WAIT with rom_cs=1 -> rom_cs, ch0_ok and ch1_ok go to 0 before the next clock edge; after release, state is IDLE and the first tie grants ch0.

Source files
------------

// File: rtl/jt7759_pkg.sv
// Shared constants and types for the jt7759 sample-ROM arbiter.
package jt7759_pkg;
  localparam int CH_AW      = 17;
  localparam int ROM_AW_DEF = 18;
  localparam int NUM_CH     = 2;

  localparam logic [2:0] ST_IDLE  = 3'b001;
  localparam logic [2:0] ST_ISSUE = 3'b010;
  localparam logic [2:0] ST_WAIT  = 3'b100;

  typedef struct packed {
    logic             en;
    logic [CH_AW-1:0] tag;
    logic [7:0]       data;
  } slot_wr_t;
endpackage

// File: rtl/jt7759_romarb_slot.sv
// One-entry holding register for a channel: tag/data/valid plus hit detection.
module jt7759_romarb_slot
  import jt7759_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cs,
  input  logic [CH_AW-1:0] addr,
  input  slot_wr_t         wr,
  output logic [7:0]       data,
  output logic             ok
);
  logic [CH_AW-1:0] tag;
  logic             valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag   <= '0;
      data  <= '0;
      valid <= 1'b0;
    end else begin
      if (wr.en) begin
        tag  <= wr.tag;
        data <= wr.data;
      end
      // A dropped request invalidates the slot even if a fill lands this cycle.
      if (!cs)        valid <= 1'b0;
      else if (wr.en) valid <= 1'b1;
    end
  end

  assign ok = cs & valid & (tag == addr);
endmodule

// File: rtl/jt7759_romarb.sv
// Two-channel jt7759 ROM arbiter: one access in flight, ch1 relocated by CH1_OFFSET.
module jt7759_romarb
  import jt7759_pkg::*;
#(
  parameter int               ROM_AW     = ROM_AW_DEF,
  parameter logic [ROM_AW-1:0] CH1_OFFSET = 'h20000,
  parameter bit               PRIO       = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ch0_cs,
  input  logic [CH_AW-1:0]  ch0_addr,
  output logic [7:0]        ch0_data,
  output logic              ch0_ok,
  input  logic              ch1_cs,
  input  logic [CH_AW-1:0]  ch1_addr,
  output logic [7:0]        ch1_data,
  output logic              ch1_ok,
  output logic              rom_cs,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  input  logic              rom_ok
);
  logic [2:0]                    state;
  logic                          gnt, last_gnt, gnt_nxt;
  logic [CH_AW-1:0]              lat_addr;
  logic [NUM_CH-1:0]             cs, ok, pend;
  logic [NUM_CH-1:0][CH_AW-1:0]  addr;
  logic [NUM_CH-1:0][7:0]        data;
  slot_wr_t [NUM_CH-1:0]         wr;
  logic [ROM_AW-1:0]             rom_addr_nxt;

  assign cs       = {ch1_cs, ch0_cs};
  assign addr     = {ch1_addr, ch0_addr};
  assign ch0_data = data[0];
  assign ch1_data = data[1];
  assign ch0_ok   = ok[0];
  assign ch1_ok   = ok[1];
  assign pend     = cs & ~ok;

  always_comb begin
    gnt_nxt = pend[1];
    if (&pend) gnt_nxt = PRIO ? 1'b0 : ~last_gnt;
  end

  assign rom_addr_nxt = ROM_AW'(addr[gnt_nxt]) + (gnt_nxt ? CH1_OFFSET : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      gnt      <= 1'b0;
      last_gnt <= 1'b1;
      lat_addr <= '0;
      rom_cs   <= 1'b0;
      rom_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: if (|pend) begin
          gnt      <= gnt_nxt;
          lat_addr <= addr[gnt_nxt];
          rom_cs   <= 1'b1;
          rom_addr <= rom_addr_nxt;
          state    <= ST_ISSUE;
        end
        // rom_ok here may belong to a previous request, so it is ignored.
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: if (rom_ok) begin
          last_gnt <= gnt;
          rom_cs   <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          rom_cs <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr[i] = {(state == ST_WAIT) && rom_ok && (gnt == 1'(i)), lat_addr, rom_data};

    jt7759_romarb_slot u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .cs    (cs[i]),
      .addr  (addr[i]),
      .wr    (wr[i]),
      .data  (data[i]),
      .ok    (ok[i])
    );
  end
endmodule

// File: tb/tb_jt7759_romarb.sv
// Directed bench for jt7759_romarb: three instances (default, wrapped offset, fixed priority).
module tb_jt7759_romarb;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ch0_cs = 1'b0, ch1_cs = 1'b0;
  logic [16:0] ch0_addr = '0, ch1_addr = '0;
  logic        ch0_ok[3], ch1_ok[3], rom_cs[3], rom_ok[3];
  logic [7:0]  ch0_data[3], ch1_data[3], rom_data[3];
  logic [17:0] rom_addr[3];
  int          lat = 0;
  int          nrun = 0, nfail = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] rd(input logic [17:0] a);
    return a[7:0] ^ a[17:10] ^ 8'h59;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic rok = 1'b0;
    int   cnt = 0;

    jt7759_romarb #(
      .ROM_AW     (18),
      .CH1_OFFSET (g == 1 ? 18'h30000 : 18'h20000),
      .PRIO       (g == 2)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ch0_cs   (ch0_cs),
      .ch0_addr (ch0_addr),
      .ch0_data (ch0_data[g]),
      .ch0_ok   (ch0_ok[g]),
      .ch1_cs   (ch1_cs),
      .ch1_addr (ch1_addr),
      .ch1_data (ch1_data[g]),
      .ch1_ok   (ch1_ok[g]),
      .rom_cs   (rom_cs[g]),
      .rom_addr (rom_addr[g]),
      .rom_data (rom_data[g]),
      .rom_ok   (rom_ok[g])
    );

    // ROM model: rom_ok lat+1 cycles after rom_cs rises, one-cycle pulse.
    always @(posedge clk) begin
      if (!rom_cs[g] || rok) begin
        cnt <= 0;
        rok <= 1'b0;
      end else begin
        cnt <= cnt + 1;
        rok <= (cnt == lat);
      end
    end
    assign rom_ok[g]   = rok;
    assign rom_data[g] = rd(rom_addr[g]);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nrun++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    ch0_cs = 1'b0;
    ch1_cs = 1'b0;
    lat    = 0;
    @(posedge clk); #1;
    rst_n  = 1'b1;
  endtask

  // Both channels request; a served channel moves to a new address as its data lands.
  task automatic arb(input int g, input int max0, input logic [3:0] exp, input string nm);
    int   ng = 0, n0 = 0, last_issue = -1;
    logic prev = 1'b0, cur, b0, b1;
    do_reset();
    ch0_addr = 17'h00100;
    ch1_addr = 17'h00200;
    ch0_cs   = 1'b1;
    ch1_cs   = 1'b1;
    for (int cyc = 0; cyc < 60 && ng < 4; cyc++) begin
      @(negedge clk);
      b0 = 1'b0;
      b1 = 1'b0;
      if (rom_cs[g] && !prev) begin
        cur = rom_addr[g][17];
        chk({nm, " grant"}, 32'(cur), 32'(exp[ng]));
        if (last_issue >= 0) chk({nm, " spacing"}, 32'(cyc - last_issue), 32'd3);
        last_issue = cyc;
        ng++;
        if (!cur) n0++;
      end
      prev = rom_cs[g];
      if (rom_cs[g] && rom_ok[g]) begin
        if (rom_addr[g][17]) b1 = 1'b1;
        else if (n0 < max0)  b0 = 1'b1;
      end
      @(posedge clk); #1;
      if (b0) ch0_addr = ch0_addr + 17'd1;
      if (b1) ch1_addr = ch1_addr + 17'd1;
    end
    chk({nm, " grants seen"}, 32'(ng), 32'd4);
  endtask

  typedef struct {
    logic        c0;
    logic [16:0] a0;
    logic        c1;
    logic [16:0] a1;
    logic        rcs;
    logic [17:0] ra;
    logic [17:0] ra1;
    logic        ok0;
    logic [7:0]  d0;
    logic        ok1;
    logic [7:0]  d1;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int   n_iss;
    bit   seen, done;
    logic prev;
    logic [17:0] a_iss[2];

    // c0 a0 c1 a1 | rom_cs rom_addr(inst0) rom_addr(inst1) ok0 d0 ok1 d1
    tbl[0]  = '{1, 17'h00103, 0, 17'h00000, 0, 18'h00000, 18'h00000, 0, 8'h00, 0, 8'h00};
    tbl[1]  = '{1, 17'h00103, 0, 17'h00000, 1, 18'h00103, 18'h00103, 0, 8'h00, 0, 8'h00};
    tbl[2]  = '{1, 17'h00103, 0, 17'h00000, 1, 18'h00103, 18'h00103, 0, 8'h00, 0, 8'h00};
    tbl[3]  = '{1, 17'h00103, 0, 17'h00000, 0, 18'h00103, 18'h00103, 1, 8'h5A, 0, 8'h00};
    tbl[4]  = '{1, 17'h00103, 1, 17'h1FFFF, 0, 18'h00103, 18'h00103, 1, 8'h5A, 0, 8'h00};
    tbl[5]  = '{1, 17'h00103, 1, 17'h1FFFF, 1, 18'h3FFFF, 18'h0FFFF, 1, 8'h5A, 0, 8'h00};
    tbl[6]  = '{1, 17'h00103, 1, 17'h1FFFF, 1, 18'h3FFFF, 18'h0FFFF, 1, 8'h5A, 0, 8'h00};
    tbl[7]  = '{1, 17'h00103, 1, 17'h1FFFF, 0, 18'h3FFFF, 18'h0FFFF, 1, 8'h5A, 1, 8'h59};
    tbl[8]  = '{0, 17'h00103, 0, 17'h1FFFF, 0, 18'h3FFFF, 18'h0FFFF, 0, 8'h5A, 0, 8'h59};
    tbl[9]  = '{1, 17'h00103, 0, 17'h1FFFF, 0, 18'h3FFFF, 18'h0FFFF, 0, 8'h5A, 0, 8'h59};
    tbl[10] = '{1, 17'h00103, 0, 17'h1FFFF, 1, 18'h00103, 18'h00103, 0, 8'h5A, 0, 8'h59};
    tbl[11] = '{1, 17'h00103, 0, 17'h1FFFF, 1, 18'h00103, 18'h00103, 0, 8'h5A, 0, 8'h59};
    tbl[12] = '{1, 17'h00103, 0, 17'h1FFFF, 0, 18'h00103, 18'h00103, 1, 8'h5A, 0, 8'h59};

    // reset state
    @(negedge clk);
    chk("reset rom_cs", 32'(rom_cs[0]), 32'd0);
    chk("reset rom_addr", 32'(rom_addr[0]), 32'd0);
    chk("reset ch0_ok", 32'(ch0_ok[0]), 32'd0);
    chk("reset ch0_data", 32'(ch0_data[0]), 32'd0);
    chk("reset ch1_data", 32'(ch1_data[0]), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // single fetch, ch1 offset/wrap, one-cycle cs drop refetch
    for (int k = 0; k < 13; k++) begin
      @(posedge clk); #1;
      ch0_cs   = tbl[k].c0;
      ch0_addr = tbl[k].a0;
      ch1_cs   = tbl[k].c1;
      ch1_addr = tbl[k].a1;
      @(negedge clk);
      chk($sformatf("row%0d rom_cs", k), 32'(rom_cs[0]), 32'(tbl[k].rcs));
      chk($sformatf("row%0d rom_addr", k), 32'(rom_addr[0]), 32'(tbl[k].ra));
      chk($sformatf("row%0d rom_addr wrap", k), 32'(rom_addr[1]), 32'(tbl[k].ra1));
      chk($sformatf("row%0d ch0_ok", k), 32'(ch0_ok[0]), 32'(tbl[k].ok0));
      chk($sformatf("row%0d ch0_data", k), 32'(ch0_data[0]), 32'(tbl[k].d0));
      chk($sformatf("row%0d ch1_ok", k), 32'(ch1_ok[0]), 32'(tbl[k].ok1));
      chk($sformatf("row%0d ch1_data", k), 32'(ch1_data[0]), 32'(tbl[k].d1));
    end

    // contention: round-robin alternates, fixed priority starves ch1 while ch0 pends
    arb(0, 99, 4'b1010, "rr");
    arb(2, 3, 4'b1000, "prio");

    // address change during WAIT: old access completes, only the new address hits
    do_reset();
    lat      = 2;
    ch0_addr = 17'h00010;
    ch0_cs   = 1'b1;
    n_iss    = 0;
    seen     = 1'b0;
    prev     = 1'b0;
    a_iss[0] = '0;
    a_iss[1] = '0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      done = 1'b0;
      if (rom_cs[0] && !prev) begin
        if (n_iss < 2) a_iss[n_iss] = rom_addr[0];
        n_iss++;
        done = (n_iss == 1);
      end
      if (rom_cs[0] && n_iss == 1) chk("addrchg held addr", 32'(rom_addr[0]), 32'h10);
      if (ch0_ok[0]) begin
        seen = 1'b1;
        chk("addrchg ok after refetch", 32'(n_iss), 32'd2);
        chk("addrchg data", 32'(ch0_data[0]), 32'(rd(18'h00011)));
      end
      prev = rom_cs[0];
      @(posedge clk); #1;
      if (done) ch0_addr = 17'h00011;
    end
    chk("addrchg ok seen", 32'(seen), 32'd1);
    chk("addrchg first addr", 32'(a_iss[0]), 32'h10);
    chk("addrchg second addr", 32'(a_iss[1]), 32'h11);

    // reset in WAIT drops rom_cs and ok asynchronously; first tie then goes to ch0
    do_reset();
    ch1_addr = 17'h00050;
    ch1_cs   = 1'b1;
    seen     = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = ch1_ok[0];
    end
    chk("rstwait ch1 fill", 32'(seen), 32'd1);
    @(posedge clk); #1;
    lat      = 5;
    ch0_addr = 17'h00040;
    ch0_cs   = 1'b1;
    n_iss    = 0;
    for (int c = 0; c < 10 && n_iss < 2; c++) begin
      @(negedge clk);
      n_iss = rom_cs[0] ? n_iss + 1 : 0;
    end
    chk("rstwait in wait", 32'(n_iss), 32'd2);
    chk("rstwait ch1_ok before", 32'(ch1_ok[0]), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstwait rom_cs", 32'(rom_cs[0]), 32'd0);
    chk("rstwait ch0_ok", 32'(ch0_ok[0]), 32'd0);
    chk("rstwait ch1_ok", 32'(ch1_ok[0]), 32'd0);
    @(posedge clk); #1;
    rst_n    = 1'b1;
    lat      = 0;
    ch0_addr = 17'h00060;
    ch1_addr = 17'h00070;
    seen     = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (rom_cs[0]) begin
        seen = 1'b1;
        chk("rstwait first tie", 32'(rom_addr[0]), 32'h00060);
      end
    end
    chk("rstwait issue seen", 32'(seen), 32'd1);

    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end
endmodule
